// File: rtl/multi_channel_com.sv
// Per-channel centre-of-mass tracker: accumulates x/y sums and counts per mask channel and
// divides them serially at frame end. Optional COM_DROP_COUNT_EN adds a dropped-frame counter.

module multi_channel_com_acc #(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int CNT_WIDTH = 17
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [H_WIDTH-1:0]           i_x,
  input  logic [V_WIDTH-1:0]           i_y,
  input  logic                         i_vld,
  input  logic                         i_clr,
  output logic [H_WIDTH+CNT_WIDTH-1:0] o_sum_x,
  output logic [V_WIDTH+CNT_WIDTH-1:0] o_sum_y,
  output logic [CNT_WIDTH-1:0]         o_cnt
);
  localparam int SXW = H_WIDTH + CNT_WIDTH;
  localparam int SYW = V_WIDTH + CNT_WIDTH;

  logic [SXW-1:0]       r_sum_x;
  logic [SYW-1:0]       r_sum_y;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Clearing wins over accumulation but still admits the pixel of the clearing cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_sum_x <= i_vld ? SXW'(i_x) : '0;
      r_sum_y <= i_vld ? SYW'(i_y) : '0;
      r_cnt   <= i_vld ? CNT_WIDTH'(1) : '0;
    end else if (i_vld && !(&r_cnt)) begin
      r_sum_x <= r_sum_x + SXW'(i_x);
      r_sum_y <= r_sum_y + SYW'(i_y);
      r_cnt   <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_sum_x = r_sum_x;
  assign o_sum_y = r_sum_y;
  assign o_cnt   = r_cnt;
endmodule

module multi_channel_com #(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int N_CH      = 2,
  parameter int CNT_WIDTH = 17,
  parameter int MIN_COUNT = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [H_WIDTH-1:0]        x_in,
  input  logic [V_WIDTH-1:0]        y_in,
  input  logic [N_CH-1:0]           valid_in,
  input  logic                      tabulate_in,
  output logic [N_CH*H_WIDTH-1:0]   x_com_out,
  output logic [N_CH*V_WIDTH-1:0]   y_com_out,
  output logic [N_CH-1:0]           found_out,
  output logic                      valid_com_out,
  output logic                      busy_out
`ifdef COM_DROP_COUNT_EN
  , output logic [7:0]              drop_count_out
`endif
);
  localparam int XW  = H_WIDTH + CNT_WIDTH;
  localparam int YW  = V_WIDTH + CNT_WIDTH;
  localparam int DW  = (XW > YW) ? XW : YW;
  localparam int BW  = $clog2(DW + 1);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_X, S_DIV_Y, S_DONE} state_t;

  state_t r_state, w_state_nx;

  logic [N_CH-1:0][XW-1:0]        w_acc_x, r_snap_x;
  logic [N_CH-1:0][YW-1:0]        w_acc_y, r_snap_y;
  logic [N_CH-1:0][CNT_WIDTH-1:0] w_acc_c, r_snap_c;

  logic [N_CH-1:0][H_WIDTH-1:0]   r_x_stg, w_x_stg_nx, r_x_com;
  logic [N_CH-1:0][V_WIDTH-1:0]   r_y_stg, w_y_stg_nx, r_y_com;
  logic [N_CH-1:0]                r_found_stg, w_found_nx, r_found;

  logic [DW-1:0]        r_dq, w_dq_nx;
  logic [CNT_WIDTH-1:0] r_rem, w_rem_nx, w_div;
  logic [CNT_WIDTH:0]   w_rem_sh;
  logic                 w_ge, w_small, w_last_ch, w_last_x, w_last_y;
  logic [BW-1:0]        r_bit;
  logic [CHW-1:0]       r_ch;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    multi_channel_com_acc #(
      .H_WIDTH  (H_WIDTH),
      .V_WIDTH  (V_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_acc (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .i_x    (x_in),
      .i_y    (y_in),
      .i_vld  (valid_in[c]),
      .i_clr  (tabulate_in),
      .o_sum_x(w_acc_x[c]),
      .o_sum_y(w_acc_y[c]),
      .o_cnt  (w_acc_c[c])
    );
  end

  // Restoring divider: r_dq holds the unconsumed dividend on top, quotient bits enter at the bottom.
  assign w_div     = r_snap_c[r_ch];
  assign w_rem_sh  = {r_rem, r_dq[DW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, w_div});
  assign w_rem_nx  = w_ge ? CNT_WIDTH'(w_rem_sh - {1'b0, w_div}) : w_rem_sh[CNT_WIDTH-1:0];
  assign w_dq_nx   = {r_dq[DW-2:0], w_ge};
  assign w_small   = (32'(w_div) < 32'(MIN_COUNT));
  assign w_last_ch = (r_ch == CHW'(N_CH - 1));
  assign w_last_x  = (r_bit == BW'(XW - 1));
  assign w_last_y  = (r_bit == BW'(YW - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_x_stg_nx = r_x_stg;
    w_y_stg_nx = r_y_stg;
    w_found_nx = r_found_stg;
    case (r_state)
      S_IDLE:  if (tabulate_in) w_state_nx = S_CHECK;
      S_CHECK: begin
        w_found_nx[r_ch] = !w_small;
        if (!w_small)      w_state_nx = S_DIV_X;
        else if (w_last_ch) w_state_nx = S_DONE;
        else               w_state_nx = S_CHECK;
      end
      S_DIV_X: if (w_last_x) begin
        w_x_stg_nx[r_ch] = w_dq_nx[H_WIDTH-1:0];
        w_state_nx       = S_DIV_Y;
      end
      S_DIV_Y: if (w_last_y) begin
        w_y_stg_nx[r_ch] = w_dq_nx[V_WIDTH-1:0];
        w_state_nx       = w_last_ch ? S_DONE : S_CHECK;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_snap_c    <= '0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_bit       <= '0;
      r_ch        <= '0;
      r_x_stg     <= '0;
      r_y_stg     <= '0;
      r_found_stg <= '0;
      r_x_com     <= '0;
      r_y_com     <= '0;
      r_found     <= '0;
    end else begin
      r_x_stg     <= w_x_stg_nx;
      r_y_stg     <= w_y_stg_nx;
      r_found_stg <= w_found_nx;
      case (r_state)
        S_IDLE: if (tabulate_in) begin
          r_snap_x <= w_acc_x;
          r_snap_y <= w_acc_y;
          r_snap_c <= w_acc_c;
          r_ch     <= '0;
        end
        S_CHECK: begin
          if (!w_small) begin
            r_dq  <= DW'(r_snap_x[r_ch]) << (DW - XW);
            r_rem <= '0;
            r_bit <= '0;
          end else begin
            r_ch <= r_ch + CHW'(1);
          end
        end
        S_DIV_X: begin
          if (w_last_x) begin
            r_dq  <= DW'(r_snap_y[r_ch]) << (DW - YW);
            r_rem <= '0;
            r_bit <= '0;
          end else begin
            r_dq  <= w_dq_nx;
            r_rem <= w_rem_nx;
            r_bit <= r_bit + BW'(1);
          end
        end
        S_DIV_Y: begin
          r_dq  <= w_dq_nx;
          r_rem <= w_rem_nx;
          r_bit <= r_bit + BW'(1);
          if (w_last_y) begin
            r_bit <= '0;
            r_ch  <= r_ch + CHW'(1);
          end
        end
        default: r_ch <= '0;
      endcase
      // Outputs change only on the edge that enters DONE, so they are coherent with valid_com_out.
      if (w_state_nx == S_DONE) begin
        r_x_com <= w_x_stg_nx;
        r_y_com <= w_y_stg_nx;
        r_found <= w_found_nx;
      end
    end
  end

  assign x_com_out     = r_x_com;
  assign y_com_out     = r_y_com;
  assign found_out     = r_found;
  assign valid_com_out = (r_state == S_DONE);
  assign busy_out      = (r_state != S_IDLE);

`ifdef COM_DROP_COUNT_EN
  logic [7:0] r_drop;
  always_ff @(posedge clk_in) begin
    if (rst_in)                                                   r_drop <= '0;
    else if (tabulate_in && r_state != S_IDLE && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
  end
  assign drop_count_out = r_drop;
`endif
endmodule

// File: tb/tb_multi_channel_com.sv
// Randomized bench for multi_channel_com against a frame-level centroid model.
module tb_multi_channel_com;
  localparam int H = 11, V = 10, N = 2, CNT = 17, MINC = 16;
  localparam int XW = H + CNT, YW = V + CNT;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [H-1:0]   x_in;
  logic [V-1:0]   y_in;
  logic [N-1:0]   valid_in;
  logic           tabulate_in;
  logic [N*H-1:0] x_com_out;
  logic [N*V-1:0] y_com_out;
  logic [N-1:0]   found_out;
  logic           valid_com_out;
  logic           busy_out;
`ifdef COM_DROP_COUNT_EN
  logic [7:0]     drop_count_out;
`endif

  multi_channel_com #(
    .H_WIDTH(H), .V_WIDTH(V), .N_CH(N), .CNT_WIDTH(CNT), .MIN_COUNT(MINC)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .x_in         (x_in),
    .y_in         (y_in),
    .valid_in     (valid_in),
    .tabulate_in  (tabulate_in),
    .x_com_out    (x_com_out),
    .y_com_out    (y_com_out),
    .found_out    (found_out),
    .valid_com_out(valid_com_out),
    .busy_out     (busy_out)
`ifdef COM_DROP_COUNT_EN
    , .drop_count_out(drop_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  longint msx[N], msy[N], mcnt[N];
  int ex[N], ey[N];
  logic [N-1:0] ef;
  int exp_lat, t_tab;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin msx[c] = 0; msy[c] = 0; mcnt[c] = 0; end
  endtask

  task automatic model_add(input int x, input int y, input logic [N-1:0] v);
    for (int c = 0; c < N; c++)
      if (v[c]) begin msx[c] += x; msy[c] += y; mcnt[c] += 1; end
  endtask

  task automatic pix(input int x, input int y, input logic [N-1:0] v);
    x_in = H'(x); y_in = V'(y); valid_in = v;
    model_add(x, y, v);
    tick();
    valid_in = '0;
  endtask

  task automatic rand_pix();
    pix($urandom_range(0, 2047), $urandom_range(0, 1023), N'($urandom_range(0, 3)));
  endtask

  task automatic square_ch0();
    for (int yy = 50; yy <= 53; yy++)
      for (int xx = 100; xx <= 103; xx++) pix(xx, yy, 2'b01);
  endtask

  // Freeze the model's expectation for the frame just closed, then open the next frame.
  task automatic tab_start(input int x, input int y, input logic [N-1:0] v);
    int nf;
    nf = 0;
    for (int c = 0; c < N; c++) begin
      ef[c] = (mcnt[c] >= MINC);
      if (ef[c]) begin
        ex[c] = int'((msx[c] / mcnt[c]) % (1 << H));
        ey[c] = int'((msy[c] / mcnt[c]) % (1 << V));
        nf++;
      end
    end
    exp_lat = N + 1 + nf * (XW + YW);
    model_clear();
    model_add(x, y, v);
    x_in = H'(x); y_in = V'(y); valid_in = v; tabulate_in = 1'b1;
    t_tab = cyc;
    tick();
    tabulate_in = 1'b0; valid_in = '0;
    chk("busy_start", busy_out, 1);
  endtask

  task automatic wait_result();
    while (!valid_com_out && (cyc - t_tab) < 400) tick();
    chk("vld_seen", valid_com_out, 1);
    chk("latency", cyc - t_tab, exp_lat);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("x_com%0d", c), x_com_out[c*H +: H], ex[c]);
      chk($sformatf("y_com%0d", c), y_com_out[c*V +: V], ey[c]);
    end
    chk("found", found_out, ef);
    tick();
    chk("vld_pulse", valid_com_out, 0);
    chk("busy_end", busy_out, 0);
  endtask

  task automatic count_valid(input int n, output int np);
    np = 0;
    repeat (n) begin tick(); if (valid_com_out) np++; end
  endtask

  initial begin
    int np;
    rst_in = 1'b1; tabulate_in = 1'b0; valid_in = '0; x_in = '0; y_in = '0;
    model_clear();
    for (int c = 0; c < N; c++) begin ex[c] = 0; ey[c] = 0; end
    repeat (3) tick();
    chk("rst_x", x_com_out, 0);
    chk("rst_y", y_com_out, 0);
    chk("rst_found", found_out, 0);
    chk("rst_vld", valid_com_out, 0);
    chk("rst_busy", busy_out, 0);
    rst_in = 1'b0;
    tick();

    // 4x4 square on ch0
    square_ch0();
    tab_start(0, 0, '0);
    wait_result();
    chk("sq_x_abs", x_com_out[H-1:0], 101);
    chk("sq_y_abs", y_com_out[V-1:0], 51);

    // disjoint blobs, ch1 a 16-pixel row
    square_ch0();
    for (int xx = 7; xx <= 22; xx++) pix(xx, 20, 2'b10);
    tab_start(0, 0, '0);
    wait_result();
    chk("row_x_abs", x_com_out[H +: H], 14);

    // ch1 one pixel short: not found, previous centroid held
    square_ch0();
    for (int xx = 7; xx <= 21; xx++) pix(xx, 300, 2'b10);
    tab_start(0, 0, '0);
    wait_result();

    // empty frame
    tab_start(0, 0, '0);
    wait_result();

    // second tabulate while busy is dropped but still clears the accumulators
    square_ch0();
    tab_start(0, 0, '0);
    repeat (19) rand_pix();
    model_clear();
    model_add(33, 44, 2'b11);
    x_in = H'(33); y_in = V'(44); valid_in = 2'b11; tabulate_in = 1'b1;
    tick();
    tabulate_in = 1'b0; valid_in = '0;
    wait_result();
`ifdef COM_DROP_COUNT_EN
    chk("drop_cnt", drop_count_out, 1);
`endif
    count_valid(150, np);
    chk("no_extra_vld", np, 0);

    // random frames; the tabulate-cycle pixel belongs to the next frame
    for (int f = 0; f < 10; f++) begin
      int npix;
      npix = $urandom_range(0, 40);
      repeat (npix) rand_pix();
      tab_start($urandom_range(0, 2047), $urandom_range(0, 1023), N'($urandom_range(0, 3)));
      wait_result();
    end

    // reset during DIV_X of ch0
    square_ch0();
    tab_start(0, 0, '0);
    repeat (10) tick();
    rst_in = 1'b1;
    tick();
    chk("mid_rst_x", x_com_out, 0);
    chk("mid_rst_y", y_com_out, 0);
    chk("mid_rst_found", found_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_vld", valid_com_out, 0);
    rst_in = 1'b0;
    model_clear();
    for (int c = 0; c < N; c++) begin ex[c] = 0; ey[c] = 0; end
    count_valid(150, np);
    chk("rst_no_vld", np, 0);
`ifdef COM_DROP_COUNT_EN
    chk("rst_drop_cnt", drop_count_out, 0);
`endif

    // normal operation after the abort
    square_ch0();
    tab_start(0, 0, '0);
    wait_result();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
